// File: rtl/clock_pkg.sv
// Constants shared by the timekeeping core and the alarm stage.
// Also provides the two-digit BCD increment helper.
package clock_pkg;

  localparam int unsigned BCD_W           = 8;
  localparam logic [7:0]  HR_MAX          = 8'h23;
  localparam logic [7:0]  MS_MAX          = 8'h59;
  localparam int unsigned DEFAULT_CLK_DIV = 50_000_000;

  // Next BCD value, wrapping to 00 once max is reached.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] q,
                                               input logic [BCD_W-1:0] max);
    if (q == max) begin
      return 8'h00;
    end
    if (q[3:0] == 4'd9) begin
      return {q[7:4] + 4'd1, 4'd0};
    end
    return {q[7:4], q[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_BCD.
// The wrap output flags the increment that rolls the counter over.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_BCD   = MS_MAX,
  parameter logic [BCD_W-1:0] RESET_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             wrap
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= bcd_inc(r_q, MAX_BCD);
    end
  end

  assign q    = r_q;
  assign wrap = inc & ~clr & (r_q == MAX_BCD);

endmodule

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz prescaler plus BCD hh:mm:ss (24 h).
// Set mode freezes counting and lets change toggles bump hours or minutes.
module time_counter
  import clock_pkg::*;
#(
  parameter int unsigned      CLK_DIV  = DEFAULT_CLK_DIV,
  parameter logic [BCD_W-1:0] RESET_HR = 8'h12
) (
  input  logic       time_clk,
  input  logic       rst_n,
  input  logic       time_set,
  input  logic       change,
  input  logic       turn,
  output logic [3:0] hr_high,
  output logic [3:0] hr_low,
  output logic [3:0] min_high,
  output logic [3:0] min_low,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic       tick_1hz,
  output logic       hour_pulse,
  output logic       LED_hr,
  output logic       LED_min
);

  localparam int unsigned    PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic             r_tick;
  logic             r_hour_pulse;
  logic             r_change_t;
  logic             r_set_t;
  logic             r_armed;
  logic             w_run;
  logic             w_edge;
  logic             w_set_inc;
  logic             w_sec_inc;
  logic             w_sec_clr;
  logic             w_min_inc;
  logic             w_hr_inc;
  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic             w_hr_wrap;
  logic [BCD_W-1:0] w_sec;
  logic [BCD_W-1:0] w_min;
  logic [BCD_W-1:0] w_hr;

  assign w_run = ~time_set;

  // Prescaler parks at 0 in set mode so the first run tick is a full period away.
  always_comb begin
    w_presc_nxt = '0;
    if (w_run && (r_presc != PRESC_LAST)) begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  always_ff @(posedge time_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_tick       <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_change_t   <= 1'b0;
      r_set_t      <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_tick       <= w_run && (w_presc_nxt == PRESC_LAST);
      r_hour_pulse <= r_tick & w_min_wrap;
      r_change_t   <= change;
      r_set_t      <= time_set;
      r_armed      <= 1'b1;
    end
  end

  // A set increment needs a settled set mode and an armed detector; ticks take priority.
  assign w_edge    = r_armed & time_set & (r_set_t == time_set) & (r_change_t != change);
  assign w_set_inc = w_edge & ~r_tick;

  assign w_sec_inc = r_tick;
  assign w_sec_clr = w_set_inc & ~turn;
  assign w_min_inc = w_sec_wrap | (w_set_inc & ~turn);
  assign w_hr_inc  = (r_tick & w_min_wrap) | (w_set_inc & turn);

  bcd_mod_counter #(.MAX_BCD(MS_MAX), .RESET_VAL(8'h00)) u_sec (
    .clk  (time_clk),
    .rst_n(rst_n),
    .inc  (w_sec_inc),
    .clr  (w_sec_clr),
    .q    (w_sec),
    .wrap (w_sec_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(MS_MAX), .RESET_VAL(8'h00)) u_min (
    .clk  (time_clk),
    .rst_n(rst_n),
    .inc  (w_min_inc),
    .clr  (1'b0),
    .q    (w_min),
    .wrap (w_min_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(HR_MAX), .RESET_VAL(RESET_HR)) u_hr (
    .clk  (time_clk),
    .rst_n(rst_n),
    .inc  (w_hr_inc),
    .clr  (1'b0),
    .q    (w_hr),
    .wrap (w_hr_wrap)
  );

  assign hr_high    = w_hr[7:4];
  assign hr_low     = w_hr[3:0];
  assign min_high   = w_min[7:4];
  assign min_low    = w_min[3:0];
  assign sec_high   = w_sec[7:4];
  assign sec_low    = w_sec[3:0];
  assign tick_1hz   = r_tick;
  assign hour_pulse = r_hour_pulse;
  assign LED_hr     = time_set & turn;
  assign LED_min    = time_set & ~turn;

  logic w_unused;
  assign w_unused = w_hr_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with a 4-cycle prescaler.
module tb_time_counter;

  logic       time_clk;
  logic       rst_n;
  logic       time_set;
  logic       change;
  logic       turn;
  logic [3:0] hr_high, hr_low, min_high, min_low, sec_high, sec_low;
  logic       tick_1hz;
  logic       hour_pulse;
  logic       LED_hr;
  logic       LED_min;
  logic [23:0] w_time;

  int n_asrt = 0;
  int n_fail = 0;

  time_counter #(.CLK_DIV(4), .RESET_HR(8'h12)) dut (
    .time_clk  (time_clk),
    .rst_n     (rst_n),
    .time_set  (time_set),
    .change    (change),
    .turn      (turn),
    .hr_high   (hr_high),
    .hr_low    (hr_low),
    .min_high  (min_high),
    .min_low   (min_low),
    .sec_high  (sec_high),
    .sec_low   (sec_low),
    .tick_1hz  (tick_1hz),
    .hour_pulse(hour_pulse),
    .LED_hr    (LED_hr),
    .LED_min   (LED_min)
  );

  assign w_time = {hr_high, hr_low, min_high, min_low, sec_high, sec_low};

  initial begin
    time_clk = 1'b0;
    forever #5 time_clk = ~time_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge time_clk);
    #1;
  endtask

  task automatic toggle();
    change = ~change;
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    time_set = 1'b0;
    change   = 1'b0;
    turn     = 1'b0;
    #22;
    chk("reset_time", 32'(w_time), 32'h120000);
    chk("reset_tick", 32'(tick_1hz), 32'h0);
    chk("reset_hp", 32'(hour_pulse), 32'h0);
    chk("reset_leds", 32'({LED_hr, LED_min}), 32'h0);

    // Run from reset: tick every 4th cycle, seconds follow one cycle later
    @(negedge time_clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("run_tick", 32'(tick_1hz), ((i == 3) || (i == 7)) ? 32'h1 : 32'h0);
      chk("run_time", 32'(w_time), 32'h120000 + 32'(i / 4));
    end

    // Set hours: 13 toggles from 12 wraps through 23 to 01
    time_set = 1'b1;
    turn     = 1'b1;
    step();
    chk("led_hr", 32'({LED_hr, LED_min}), 32'h2);
    repeat (12) toggle();
    chk("set_hr_wrap", 32'(w_time), 32'h000002);
    chk("set_hr_wrap_hp", 32'(hour_pulse), 32'h0);
    toggle();
    chk("set_hr_13", 32'(w_time), 32'h010002);
    repeat (22) toggle();
    chk("set_hr_23", 32'(w_time), 32'h230002);

    // Set minutes: seconds clear, 59 -> 00 does not carry into hours
    turn = 1'b0;
    #1;
    chk("led_min", 32'({LED_hr, LED_min}), 32'h1);
    toggle();
    chk("set_min_1", 32'(w_time), 32'h230100);
    repeat (58) toggle();
    chk("set_min_59", 32'(w_time), 32'h235900);
    toggle();
    chk("set_min_wrap", 32'(w_time), 32'h230000);
    repeat (59) toggle();
    chk("set_min_59b", 32'(w_time), 32'h235900);

    // Run 59 s to 23:59:59, then the midnight rollover
    time_set = 1'b0;
    repeat (236) step();
    chk("pre_midnight", 32'(w_time), 32'h235959);
    chk("pre_midnight_tick", 32'(tick_1hz), 32'h0);
    repeat (3) step();
    chk("midnight_tick", 32'(tick_1hz), 32'h1);
    chk("midnight_hp_early", 32'(hour_pulse), 32'h0);
    step();
    chk("midnight_time", 32'(w_time), 32'h000000);
    chk("midnight_hp", 32'(hour_pulse), 32'h1);
    step();
    chk("midnight_hp_drop", 32'(hour_pulse), 32'h0);

    // Toggles on a mode change and in run mode are ignored
    time_set = 1'b1;
    change   = ~change;
    step();
    chk("edge_on_set_rise", 32'(w_time), 32'h000000);
    step();
    chk("set_hold", 32'(w_time), 32'h000000);
    time_set = 1'b0;
    change   = ~change;
    step();
    toggle();
    chk("run_edges_time", 32'(w_time), 32'h000000);
    chk("run_edges_tick", 32'(tick_1hz), 32'h0);
    step();
    chk("run_edges_tick_hi", 32'(tick_1hz), 32'h1);
    step();
    chk("run_edges_sec", 32'(w_time), 32'h000001);
    chk("run_leds", 32'({LED_hr, LED_min}), 32'h0);

    // Reset in the middle of set mode, change held high through release
    time_set = 1'b1;
    turn     = 1'b1;
    step();
    toggle();
    chk("preset_hr", 32'(w_time), 32'h010001);
    #2;
    rst_n  = 1'b0;
    change = 1'b1;
    #1;
    chk("mid_set_rst_time", 32'(w_time), 32'h120000);
    chk("mid_set_rst_tick", 32'(tick_1hz), 32'h0);
    chk("mid_set_rst_hp", 32'(hour_pulse), 32'h0);
    @(negedge time_clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("held_change", 32'(w_time), 32'h120000);
    toggle();
    chk("first_toggle", 32'(w_time), 32'h130000);
    step();
    chk("first_toggle_hold", 32'(w_time), 32'h130000);

    // Reset in the middle of a prescale period
    time_set = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_presc_rst_time", 32'(w_time), 32'h120000);
    chk("mid_presc_rst_tick", 32'(tick_1hz), 32'h0);
    @(negedge time_clk);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_tick_lo", 32'(tick_1hz), 32'h0);
    step();
    chk("post_rst_tick_hi", 32'(tick_1hz), 32'h1);
    chk("post_rst_time", 32'(w_time), 32'h120000);
    step();
    chk("post_rst_sec", 32'(w_time), 32'h120001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
